// File: rtl/aes_pkg.sv
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions for the iterative SubBytes stage:
//                byte count, FSM state type and the forward S-box table.
//                The inverse S-box table is present only when
//                AES_SUB_BYTES_INV_EN is defined.
//                `AES_BLOCK_SIZE is normally supplied by aes_defines.svh; it
//                is defaulted here (guarded) so the slice builds stand-alone.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_sub_bytes_state_t;

    // Forward S-box, entry k = SubBytes(k).
    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef AES_SUB_BYTES_INV_EN
    // Inverse S-box, entry k = InvSubBytes(k).
    localparam logic [7:0] c_inv_sbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational 8-bit AES S-box lookup. With
//                AES_SUB_BYTES_INV_EN defined, i_inv selects the inverse
//                table; otherwise only the forward table exists.
//  Ports       : i_byte - byte to substitute
//                i_inv  - 1 = inverse S-box (AES_SUB_BYTES_INV_EN only)
//                o_byte - substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
`ifdef AES_SUB_BYTES_INV_EN
    input  logic       i_inv,
`endif
    output logic [7:0] o_byte
);

`ifdef AES_SUB_BYTES_INV_EN
    assign o_byte = i_inv ? c_inv_sbox[i_byte] : c_sbox[i_byte];
`else
    assign o_byte = c_sbox[i_byte];
`endif

endmodule

`default_nettype wire

// File: rtl/aes_sub_bytes_seq.sv
// ============================================================================
//  Module      : aes_sub_bytes_seq
//  Description : Iterative AES SubBytes stage. Substitutes the 16 bytes of
//                one block SBOX_COUNT bytes per cycle (GROUPS = 16/SBOX_COUNT
//                cycles), holding one block at a time behind valid/ready
//                handshakes. Output feeds aes_shift_rows directly.
//                Optional macro AES_SUB_BYTES_INV_EN adds the 'inv' port and
//                the inverse S-box (InvSubBytes) for the decrypt path.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                in_valid  - in_block valid
//                in_ready  - block can accept input (IDLE only)
//                in_block  - state to substitute, byte i = [8*i +: 8]
//                inv       - inverse mode, latched on accept (macro only)
//                out_valid - out_block valid (DONE only)
//                out_ready - downstream accepts out_block
//                out_block - substituted state, same byte ordering
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int SBOX_COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`AES_BLOCK_SIZE-1:0] in_block,
`ifdef AES_SUB_BYTES_INV_EN
    input  logic                       inv,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`AES_BLOCK_SIZE-1:0] out_block
);

    localparam int GROUPS = AES_BYTES / SBOX_COUNT;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GRP_W  = SBOX_COUNT * 8;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(GROUPS - 1);

    generate
        if (!(SBOX_COUNT == 1 || SBOX_COUNT == 2 || SBOX_COUNT == 4 ||
              SBOX_COUNT == 8 || SBOX_COUNT == 16)) begin : g_bad_sbox_count
            $error("aes_sub_bytes_seq: SBOX_COUNT must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    aes_sub_bytes_state_t r_state;
    aes_sub_bytes_state_t w_state_next;

    logic [CNT_W-1:0]           r_cnt;
    logic [`AES_BLOCK_SIZE-1:0] r_work;
    logic [`AES_BLOCK_SIZE-1:0] r_out;
    logic [`AES_BLOCK_SIZE-1:0] w_work_next;
    logic [GRP_W-1:0]           w_grp_in;
    logic [GRP_W-1:0]           w_grp_out;
    logic [6:0]                 w_base;
    logic                       w_in_ready;
    logic                       w_out_valid;
    logic                       w_load;
    logic                       w_step;
    logic                       w_last;

    assign w_last = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded controls. Handshake outputs depend on
    // r_state alone; in_valid/out_ready only steer the next state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_block = r_out;

    // ------------------------------------------------------------------
    // Datapath: the current group of bytes goes through the S-boxes and
    // is written back in place.
    // ------------------------------------------------------------------
    assign w_base   = 7'(r_cnt) * 7'(GRP_W);
    assign w_grp_in = r_work[w_base +: GRP_W];

    always_comb begin
        w_work_next                   = r_work;
        w_work_next[w_base +: GRP_W]  = w_grp_out;
    end

`ifdef AES_SUB_BYTES_INV_EN
    logic r_inv;

    // Mode is captured with the block so a toggling 'inv' cannot corrupt
    // the block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (w_load) begin
            r_inv <= inv;
        end
    end
`endif

    generate
        for (genvar k = 0; k < SBOX_COUNT; k++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_grp_in[8*k +: 8]),
`ifdef AES_SUB_BYTES_INV_EN
                .i_inv  (r_inv),
`endif
                .o_byte (w_grp_out[8*k +: 8])
            );
        end
    endgenerate

    // r_out is a separate register so out_block holds the previous result
    // while the next block is being worked on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_out  <= '0;
        end else begin
            if (w_load) begin
                r_work <= in_block;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_work <= w_work_next;
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_step && w_last) begin
                r_out <= w_work_next;
            end
        end
    end

endmodule

`default_nettype wire
